// File: rtl/pong_ball_engine_pkg.sv
// Shared types and constants for the pong ball engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_pkg;

  localparam int VEL_W  = 4;   // signed velocity width
  localparam int POS_W  = 10;  // screen coordinate width
  localparam int CALC_W = 12;  // signed width for next-position maths
  localparam int ZONE_W = 3;

  // Bit positions inside a paddle zone vector {top,mid,bot}
  localparam int ZONE_TOP = 2;
  localparam int ZONE_MID = 1;
  localparam int ZONE_BOT = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2
  } state_t;

  typedef logic signed [VEL_W-1:0] vel_t;

  // Vertical nudge from the paddle zone that struck the ball. Only a single
  // top or bottom bit deflects; mid alone or any multi-bit pattern counts as mid.
  function automatic vel_t zone_delta(input logic [ZONE_W-1:0] zone);
    logic [ZONE_W-1:0] top_only;
    logic [ZONE_W-1:0] bot_only;
    vel_t              d;
    top_only           = '0;
    top_only[ZONE_TOP] = 1'b1;
    bot_only           = '0;
    bot_only[ZONE_BOT] = 1'b1;
    d                  = vel_t'(0);
    if (zone == top_only) begin
      d = vel_t'(-1);
    end else if (zone == bot_only) begin
      d = vel_t'(1);
    end
    return d;
  endfunction

endpackage

// File: rtl/pong_ball_engine_if.sv
// Frame-tick, video-scan, serve/paddle inputs and ball state outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the master drives inputs every cycle.
interface pong_ball_engine_if;
  import pong_pkg::*;

  logic              en;
  logic [POS_W-1:0]  x;
  logic [POS_W-1:0]  y;
  logic              visible;
  logic              srv_l;
  logic              srv_r;
  logic [ZONE_W-1:0] hit_l;
  logic [ZONE_W-1:0] hit_r;
  logic [11:0]       rgb;
  logic [POS_W-1:0]  ball_x;
  logic [POS_W-1:0]  ball_y;
  vel_t              vx;
  vel_t              vy;
  logic              miss_l;
  logic              miss_r;
  logic              busy;

  modport master (
    output en, x, y, visible, srv_l, srv_r, hit_l, hit_r,
    input  rgb, ball_x, ball_y, vx, vy, miss_l, miss_r, busy
  );

  modport slave (
    input  en, x, y, visible, srv_l, srv_r, hit_l, hit_r,
    output rgb, ball_x, ball_y, vx, vy, miss_l, miss_r, busy
  );

endinterface

// File: rtl/pong_vel_sat.sv
// Signed add clamped to +/-LIMIT.
// Latency: combinational.
// Backpressure: none.
module pong_vel_sat #(
  parameter int W     = 4,
  parameter int LIMIT = 5
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum
);

  localparam int WP = W + 1;
  localparam logic signed [W:0] LIM_P = WP'(LIMIT);
  localparam logic signed [W:0] LIM_N = WP'(-LIMIT);

  logic signed [W:0] raw;

  // One extra bit of headroom so the clamp sees the true sum
  always_comb begin
    raw = $signed({a[W-1], a}) + $signed({b[W-1], b});
    if (raw > LIM_P) begin
      sum = LIM_P[W-1:0];
    end else if (raw < LIM_N) begin
      sum = LIM_N[W-1:0];
    end else begin
      sum = raw[W-1:0];
    end
  end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball: serve, wall bounce, paddle deflection/speed-up, miss detect, pixel.
// Latency: state updates one clk after an en tick; rgb is combinational.
// Backpressure: none; every en tick is consumed.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int          BALL_W       = 10,
  parameter int          BALL_H       = 10,
  parameter int          START_X      = 394,
  parameter int          START_Y      = 324,
  parameter int          LEFT_LIMIT   = 0,
  parameter int          RIGHT_LIMIT  = 799,
  parameter int          TOP_BOUND    = 136,
  parameter int          BOTTOM_BOUND = 502,
  parameter int          VX_INIT      = 2,
  parameter int          VX_MAX       = 6,
  parameter int          VY_MAX       = 5,
  parameter int          SPEEDUP_HITS = 4,
  parameter int          SCORE_HOLD   = 60,
  parameter logic [11:0] COLOR        = 12'hfff
) (
  input  logic               clk,
  input  logic               reset,
  pong_ball_engine_if.slave  io
);

  localparam int HIT_W  = $clog2(SPEEDUP_HITS + 1);
  localparam int HOLD_W = $clog2(SCORE_HOLD + 1);
  localparam int PW1    = POS_W + 1;

  localparam logic signed [CALC_W-1:0] LEFT_S  = CALC_W'(LEFT_LIMIT);
  localparam logic signed [CALC_W-1:0] RIGHT_S = CALC_W'(RIGHT_LIMIT);
  localparam logic signed [CALC_W-1:0] TOP_S   = CALC_W'(TOP_BOUND);
  localparam logic signed [CALC_W-1:0] BOT_S   = CALC_W'(BOTTOM_BOUND);
  localparam vel_t VX_INIT_V = vel_t'(VX_INIT);
  localparam vel_t VY_MAX_V  = vel_t'(VY_MAX);

  state_t            state_q, state_d;
  logic [POS_W-1:0]  ball_x_q, ball_x_d;
  logic [POS_W-1:0]  ball_y_q, ball_y_d;
  vel_t              vx_q, vx_d;
  vel_t              vy_q, vy_d;
  vel_t              srv_cnt_q, srv_cnt_d;
  logic [HIT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              miss_l_q, miss_l_d;
  logic              miss_r_q, miss_r_d;

  logic signed [CALC_W-1:0] nx, ny;
  logic [POS_W-1:0]  y_wall, x_hit;
  vel_t              vy_wall, vy_hit, vx_mag, vx_mag_new, srv_next;
  logic              moving_l, moving_r, acc_l, acc_r, speedup;
  logic [ZONE_W-1:0] zone;
  logic [PW1-1:0]    x_end, y_end;

  // Next-position arithmetic, wide and signed so screen edges never wrap
  assign nx = $signed({{(CALC_W-POS_W){1'b0}}, ball_x_q})
            + $signed({{(CALC_W-VEL_W){vx_q[VEL_W-1]}}, vx_q});
  assign ny = $signed({{(CALC_W-POS_W){1'b0}}, ball_y_q})
            + $signed({{(CALC_W-VEL_W){vy_q[VEL_W-1]}}, vy_q});

  // A paddle only counts while the ball is heading toward it
  assign moving_l = vx_q[VEL_W-1];
  assign moving_r = !vx_q[VEL_W-1] && (vx_q != vel_t'(0));
  assign acc_l    = (|io.hit_l) && moving_l;
  assign acc_r    = (|io.hit_r) && moving_r;
  assign zone     = acc_l ? io.hit_l : io.hit_r;
  assign vx_mag   = moving_l ? -vx_q : vx_q;
  assign speedup  = (hit_cnt_q == HIT_W'(SPEEDUP_HITS - 1));
  assign srv_next = (srv_cnt_q == VY_MAX_V) ? -VY_MAX_V : srv_cnt_q + vel_t'(1);

  // Wall reflection: pin to the wall and mirror vy
  always_comb begin
    y_wall  = ny[POS_W-1:0];
    vy_wall = vy_q;
    if (ny <= TOP_S) begin
      y_wall  = POS_W'(TOP_BOUND);
      vy_wall = -vy_q;
    end else if (ny >= BOT_S) begin
      y_wall  = POS_W'(BOTTOM_BOUND);
      vy_wall = -vy_q;
    end
  end

  // Keep a paddle-saved ball on screen even if its step overshot the miss line
  always_comb begin
    x_hit = nx[POS_W-1:0];
    if (nx < LEFT_S) begin
      x_hit = POS_W'(LEFT_LIMIT);
    end else if (nx > RIGHT_S) begin
      x_hit = POS_W'(RIGHT_LIMIT);
    end
  end

  pong_vel_sat #(.W(VEL_W), .LIMIT(VY_MAX)) u_vy_sat (
    .a   (vy_wall),
    .b   (zone_delta(zone)),
    .sum (vy_hit)
  );

  pong_vel_sat #(.W(VEL_W), .LIMIT(VX_MAX)) u_vx_sat (
    .a   (vx_mag),
    .b   (speedup ? vel_t'(1) : vel_t'(0)),
    .sum (vx_mag_new)
  );

  // Next-state logic; everything but the miss pulse holds between en ticks
  always_comb begin
    state_d   = state_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    srv_cnt_d = srv_cnt_q;
    hit_cnt_d = hit_cnt_q;
    hold_d    = hold_q;
    miss_l_d  = 1'b0;
    miss_r_d  = 1'b0;
    if (io.en) begin
      srv_cnt_d = srv_next;
      unique case (state_q)
        ST_IDLE: begin
          if (io.srv_l ^ io.srv_r) begin
            state_d = ST_PLAY;
            vx_d    = io.srv_l ? VX_INIT_V : -VX_INIT_V;
            vy_d    = srv_cnt_q;
          end
        end
        ST_PLAY: begin
          ball_y_d = y_wall;
          if (acc_l || acc_r) begin
            ball_x_d  = x_hit;
            vy_d      = vy_hit;
            vx_d      = moving_r ? -vx_mag_new : vx_mag_new;
            hit_cnt_d = speedup ? '0 : hit_cnt_q + HIT_W'(1);
          end else if ((nx <= LEFT_S && moving_l) || (nx >= RIGHT_S && moving_r)) begin
            miss_l_d  = moving_l;
            miss_r_d  = moving_r;
            ball_x_d  = POS_W'(START_X);
            ball_y_d  = POS_W'(START_Y);
            vx_d      = vel_t'(0);
            vy_d      = vel_t'(0);
            hit_cnt_d = '0;
            hold_d    = '0;
            state_d   = ST_SCORED;
          end else begin
            ball_x_d = nx[POS_W-1:0];
            vy_d     = vy_wall;
          end
        end
        ST_SCORED: begin
          if (hold_q == HOLD_W'(SCORE_HOLD - 1)) begin
            hold_d  = '0;
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset overriding en
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ball_x_q  <= POS_W'(START_X);
      ball_y_q  <= POS_W'(START_Y);
      vx_q      <= vel_t'(0);
      vy_q      <= vel_t'(0);
      srv_cnt_q <= vel_t'(0);
      hit_cnt_q <= '0;
      hold_q    <= '0;
      miss_l_q  <= 1'b0;
      miss_r_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      srv_cnt_q <= srv_cnt_d;
      hit_cnt_q <= hit_cnt_d;
      hold_q    <= hold_d;
      miss_l_q  <= miss_l_d;
      miss_r_q  <= miss_r_d;
    end
  end

  // Ball pixel test against the live scan position
  assign x_end  = {1'b0, ball_x_q} + PW1'(BALL_W);
  assign y_end  = {1'b0, ball_y_q} + PW1'(BALL_H);
  assign io.rgb = (io.visible && (io.x >= ball_x_q) && ({1'b0, io.x} < x_end) &&
                   (io.y >= ball_y_q) && ({1'b0, io.y} < y_end)) ? COLOR : 12'h000;

  assign io.ball_x = ball_x_q;
  assign io.ball_y = ball_y_q;
  assign io.vx     = vx_q;
  assign io.vy     = vy_q;
  assign io.miss_l = miss_l_q;
  assign io.miss_r = miss_r_q;
  assign io.busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pong_ball_engine.sv
// Randomized bench for pong_ball_engine with a rule-level reference model.
// Stimulus pushes the expected post-edge state; a monitor pops and compares.
// Terminates after a fixed cycle budget.
module tb_pong_ball_engine;

  localparam int START_X = 394, START_Y = 324, LEFT = 0, RIGHT = 799;
  localparam int TOP = 136, BOT = 502, VX_INIT = 2, VX_MAX = 6, VY_MAX = 5;
  localparam int SPEEDUP = 4, HOLD = 60, BW = 10, BH = 10;
  localparam int S_IDLE = 0, S_PLAY = 1, S_SCORED = 2;

  typedef struct {
    int bx; int by; int vx; int vy; int ml; int mr; int busy; int rgb;
  } exp_t;

  logic clk;
  logic reset;
  pong_ball_engine_if ifc ();

  pong_ball_engine dut (
    .clk   (clk),
    .reset (reset),
    .io    (ifc)
  );

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int m_st, m_x, m_y, m_vx, m_vy, m_ml, m_mr, m_srv, m_hits, m_hold;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sat(int v, int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic model_step(bit rst, bit en, bit sl, bit sr, bit [2:0] hl, bit [2:0] hr);
    int nx, ny, nvy, mag, d;
    bit al, ar;
    bit [2:0] z;
    if (rst) begin
      m_st = S_IDLE; m_x = START_X; m_y = START_Y; m_vx = 0; m_vy = 0;
      m_ml = 0; m_mr = 0; m_srv = 0; m_hits = 0; m_hold = 0;
      return;
    end
    m_ml = 0;
    m_mr = 0;
    if (!en) return;
    case (m_st)
      S_IDLE: begin
        if (sl != sr) begin
          m_st = S_PLAY;
          m_vx = sl ? VX_INIT : -VX_INIT;
          m_vy = m_srv;
        end
      end
      S_PLAY: begin
        nx = m_x + m_vx;
        ny = m_y + m_vy;
        nvy = m_vy;
        if (ny <= TOP) begin m_y = TOP; nvy = -m_vy; end
        else if (ny >= BOT) begin m_y = BOT; nvy = -m_vy; end
        else m_y = ny;
        al = (hl != 0) && (m_vx < 0);
        ar = (hr != 0) && (m_vx > 0);
        if (al || ar) begin
          z = al ? hl : hr;
          d = (z == 3'b100) ? -1 : ((z == 3'b001) ? 1 : 0);
          m_vy = sat(nvy + d, VY_MAX);
          mag = (m_vx < 0) ? -m_vx : m_vx;
          m_hits++;
          if (m_hits == SPEEDUP) begin
            m_hits = 0;
            if (mag < VX_MAX) mag++;
          end
          m_vx = (m_vx > 0) ? -mag : mag;
          m_x = (nx < LEFT) ? LEFT : ((nx > RIGHT) ? RIGHT : nx);
        end else if ((nx <= LEFT && m_vx < 0) || (nx >= RIGHT && m_vx > 0)) begin
          m_ml = (m_vx < 0);
          m_mr = (m_vx > 0);
          m_x = START_X; m_y = START_Y; m_vx = 0; m_vy = 0;
          m_hits = 0; m_hold = 0; m_st = S_SCORED;
        end else begin
          m_x = nx;
          m_vy = nvy;
        end
      end
      default: begin
        m_hold++;
        if (m_hold == HOLD) begin
          m_hold = 0;
          m_st = S_IDLE;
        end
      end
    endcase
    m_srv = (m_srv == VY_MAX) ? -VY_MAX : m_srv + 1;
  endtask

  // Drive one cycle of inputs at the falling edge and queue its expectation
  task automatic drive_cycle(bit rst, bit en, bit sl, bit sr, bit [2:0] hl, bit [2:0] hr);
    int xv, yv;
    bit vis;
    exp_t ex;
    @(negedge clk);
    xv = m_x - 4 + int'($urandom_range(0, 20));
    yv = m_y - 4 + int'($urandom_range(0, 20));
    if (xv < 0) xv = 0;
    if (yv < 0) yv = 0;
    vis = ($urandom_range(0, 3) != 0);
    reset       = rst;
    ifc.en      = en;
    ifc.srv_l   = sl;
    ifc.srv_r   = sr;
    ifc.hit_l   = hl;
    ifc.hit_r   = hr;
    ifc.x       = 10'(xv);
    ifc.y       = 10'(yv);
    ifc.visible = vis;
    model_step(rst, en, sl, sr, hl, hr);
    ex.bx = m_x; ex.by = m_y; ex.vx = m_vx; ex.vy = m_vy;
    ex.ml = m_ml; ex.mr = m_mr; ex.busy = (m_st != S_IDLE) ? 1 : 0;
    ex.rgb = (vis && xv >= m_x && xv < m_x + BW && yv >= m_y && yv < m_y + BH) ? 12'hfff : 0;
    exp_q.push_back(ex);
  endtask

  task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compare DUT outputs shortly after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ball_x", ifc.ball_x, e.bx);
        chk("ball_y", ifc.ball_y, e.by);
        chk("vx", ifc.vx, e.vx);
        chk("vy", ifc.vy, e.vy);
        chk("miss_l", ifc.miss_l, e.ml);
        chk("miss_r", ifc.miss_r, e.mr);
        chk("busy", ifc.busy, e.busy);
        chk("rgb", ifc.rgb, e.rgb);
      end
    end
  end

  // Stimulus
  initial begin
    int hp, hold_left, play_ticks, prev;
    bit rst, en, sl, sr;
    bit [2:0] hl, hr;
    reset = 1'b1;
    ifc.en = 1'b0; ifc.srv_l = 1'b0; ifc.srv_r = 1'b0;
    ifc.hit_l = 3'b000; ifc.hit_r = 3'b000;
    ifc.x = '0; ifc.y = '0; ifc.visible = 1'b0;
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    hp = 0; hold_left = 0; play_ticks = 0; hl = 3'b000; hr = 3'b000;

    // Directed opening: reset, double serve ignored, left serve, first move
    repeat (3) drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 3'b000);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    hp = 4;

    for (int c = 0; c < 30000; c++) begin
      rst = ($urandom_range(0, 2999) == 0);
      en  = ($urandom_range(0, 3) != 0);
      if (m_st == S_IDLE) begin
        sl = 1'($urandom_range(0, 1));
        sr = 1'($urandom_range(0, 1));
      end else begin
        sl = ($urandom_range(0, 7) == 0);
        sr = ($urandom_range(0, 7) == 0);
      end
      if (hold_left > 0) begin
        hold_left--;
      end else begin
        hl = 3'b000;
        hr = 3'b000;
        if (m_st == S_PLAY && int'($urandom_range(0, 15)) < hp) begin
          if ($urandom_range(0, 1) == 1) hl = 3'($urandom_range(1, 7));
          else hr = 3'($urandom_range(1, 7));
          hold_left = int'($urandom_range(0, 3));
        end
      end
      prev = m_st;
      drive_cycle(rst, en, sl, sr, hl, hr);
      if (prev != S_PLAY && m_st == S_PLAY) begin
        case ($urandom_range(0, 3))
          0: hp = 0;
          1: hp = 2;
          2: hp = 4;
          default: hp = 8;
        endcase
        play_ticks = 0;
      end else if (m_st == S_PLAY && en) begin
        play_ticks++;
        if (play_ticks > 250) hp = 0;
      end
    end

    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
